// File: rtl/button_event_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : button_event_arbiter_pkg                                     |
// | Description : Shared defaults and a round-robin index helper for the      |
// |               button event arbiter and its event queue.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package button_event_arbiter_pkg;

  // Default number of debounced button channels
  localparam int DEF_N_BTN      = 4;
  // Default event queue depth (power of two, at least 2)
  localparam int DEF_FIFO_DEPTH = 4;
  // Width of the saturating drop counter
  localparam int DROP_W         = 8;

  // Channel index reached by stepping 'step' places past 'base', wrapping at 'modulo'
  function automatic int rr_index(input int base, input int step, input int modulo);
    return (base + step) % modulo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : event_fifo                                                   |
// | Description : Small circular queue of button indices. Full/empty come     |
// |               from the registered count only, so a same-cycle pop never   |
// |               opens room for a same-cycle push when full.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module event_fifo
  import button_event_arbiter_pkg::*;
#(
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  parameter int DATA_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  // An empty queue presents index 0 rather than stale storage
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : button_event_arbiter                                         |
// | Description : Latches debounced button pulses into per-button pending     |
// |               flags, round-robin grants one flag per cycle into an event  |
// |               queue, and counts re-pulses that coalesce into an already   |
// |               pending flag.                                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int N_BTN      = DEF_N_BTN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ID_W       = $clog2(N_BTN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_pulse,
  output logic              evt_valid,
  output logic [ID_W-1:0]   evt_id,
  input  logic              evt_ready,
  output logic [N_BTN-1:0]  pending,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [N_BTN-1:0]  pending_q,    pending_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [DROP_W-1:0] drop_cnt_q,   drop_cnt_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   rr_idx;
  logic [N_BTN-1:0]  grant_mask;
  logic [N_BTN-1:0]  coalesce;
  logic [DROP_W:0]   n_drop;
  logic [DROP_W:0]   drop_sum;

  logic [CNT_W-1:0]  fifo_count;
  logic [ID_W-1:0]   fifo_head;
  logic              fifo_full;
  logic              unused_fifo_empty;
  logic              fifo_pop;

  // Round-robin search starting one past the last granted channel; nothing is granted while the queue is full
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    rr_idx    = '0;
    if (!fifo_full) begin
      for (int k = 1; k <= N_BTN; k++) begin
        rr_idx = ID_W'(rr_index(int'(last_grant_q), k, N_BTN));
        if (!grant_vld && pending_q[rr_idx]) begin
          grant_vld = 1'b1;
          grant_id  = rr_idx;
        end
      end
    end
  end

  // Pending update: a grant clears its flag, but a pulse in the same cycle re-arms it as a fresh event
  always_comb begin
    grant_mask = '0;
    for (int i = 0; i < N_BTN; i++) begin
      grant_mask[i] = grant_vld && (grant_id == ID_W'(i));
    end
    coalesce     = btn_pulse & pending_q & ~grant_mask;
    pending_d    = (pending_q & ~grant_mask) | btn_pulse;
    last_grant_d = grant_vld ? grant_id : last_grant_q;
  end

  // Every coalesced pulse is one lost event; the counter sticks at its maximum
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_BTN; i++) begin
      n_drop = n_drop + {{DROP_W{1'b0}}, coalesce[i]};
    end
    drop_sum   = {1'b0, drop_cnt_q} + n_drop;
    drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  // Arbiter state; reset leaves button 0 first in line
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      last_grant_q <= ID_W'(N_BTN-1);
      drop_cnt_q   <= '0;
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign fifo_pop = evt_valid && evt_ready;

  event_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ID_W)
  ) u_event_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_vld),
    .push_data (grant_id),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (unused_fifo_empty)
  );

  // Outputs come straight from registered state, so btn_pulse never reaches evt_valid combinationally
  assign evt_valid = (fifo_count != '0);
  assign evt_id    = fifo_head;
  assign pending   = pending_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter N_BTN, default 4: number of debounced button channels.
REQ-002 Parameter FIFO_DEPTH, default 4: event queue entries; power of two, at least 2.
REQ-003 Parameter ID_W, default $clog2(N_BTN): width of the button index.
REQ-004 clk  input  1  system clock; one clock, all logic on posedge clk.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 btn_pulse  input  N_BTN  debouncer outputs; each asserted cycle is one press event.
REQ-007 evt_valid  output  1  queue head holds a valid event.
REQ-008 evt_id  output  ID_W  button index of the queue head.
REQ-009 evt_ready  input  1  consumer accepts the head this cycle.
REQ-010 pending  output  N_BTN  per-button latched, not-yet-queued event flags.
REQ-011 drop_cnt  output  8  saturating count of coalesced (lost) events.

Function
REQ-012 At each edge, pending[i] SHALL be set if btn_pulse[i]=1.
REQ-013 A pulse arriving while pending[i]=1 and bit i is not granted in that cycle SHALL be coalesced, and drop_cnt SHALL increment, saturating at 255.
REQ-014 Each cycle, the arbiter SHALL grant at most one bit i with pending[i]=1, but only if queue count < FIFO_DEPTH.
REQ-015 Grant SHALL be round-robin: search starts at last_grant+1 modulo N_BTN; last_grant updates only on a grant.
REQ-016 On a grant, the arbiter SHALL clear pending[i] and push i into the queue at the same edge.
REQ-017 If btn_pulse[i]=1 in the grant cycle, pending[i] SHALL remain 1 (new event), and drop_cnt SHALL NOT increment.
REQ-018 Latency: a pulse in cycle t with an idle queue and no other pending bits SHALL give pending[i]=1 in t+1 and evt_valid=1 with evt_id=i in t+2.
REQ-019 Pop SHALL occur when evt_valid && evt_ready; evt_ready with evt_valid=0 SHALL be ignored.
REQ-020 evt_id SHALL hold stable while evt_valid=1 and no pop occurs.
REQ-021 Simultaneous push and pop SHALL leave the count unchanged.
REQ-022 Full-queue push eligibility SHALL use the registered count: a pop in the same cycle does not enable a push when full.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH.
REQ-024 While the queue is full, pending bits SHALL be held, not dropped; only re-pulses count as drops per REQ-013.
REQ-025 evt_valid SHALL equal (count != 0), and SHALL be driven from registers with no combinational path from btn_pulse.

Reset
REQ-026 While rst=1, the block SHALL clear pending, count, pointers and drop_cnt to 0, and set last_grant to N_BTN-1 so that button 0 has first priority.
REQ-027 After reset, evt_valid=0, evt_id=0, pending=0 and drop_cnt=0 from the first cycle.
REQ-028 rst SHALL take priority over btn_pulse and evt_ready in the same cycle; queued events SHALL be discarded.
REQ-029 Reset asserted mid-operation SHALL lose all events; no partial state SHALL survive.

Structure
REQ-030 A shared package SHALL hold the default constants for N_BTN, FIFO_DEPTH and the drop-counter width.
REQ-031 The queue SHALL be a sub-module, event_fifo, with ports push, push_data, pop, head, count, full and empty, and the same clk/rst.
REQ-032 Round-robin grant logic and the pending register SHALL live in the top module.
REQ-033 The target size SHALL be 120-400 lines of RTL in total.

Verification
REQ-034 Single pulse on btn 2 at cycle 10, evt_ready=1 -> pending=0100 at cycle 11; evt_valid=1, evt_id=2 at cycle 12; evt_valid=0 at cycle 13.
REQ-035 Pulses on btns 0,1,3 in the same cycle after reset, evt_ready=1 -> events popped in order 0,1,3 on consecutive cycles; drop_cnt=0.
REQ-036 evt_ready=0, 6 distinct single pulses, btns 0,1,2,3,0,1 -> 4 events queued (0,1,2,3); pending=0011 held; then evt_ready=1 -> 0,1,2,3,0,1 delivered with none lost.
REQ-037 Queue full, btn 1 already pending, btn 1 pulses 300 times -> drop_cnt saturates at 255; pending[1] stays 1.
REQ-038 Pulse on btn 0 in its own grant cycle -> two events with id 0 are delivered; drop_cnt unchanged.
REQ-039 rst for 1 cycle with 3 queued events and pending=1010 -> next cycle evt_valid=0, pending=0, drop_cnt=0; next arbitration grants button 0 first.
